// File: rtl/conv_il_pkg.sv
// Shared helpers for the convolutional (de)interleaver: branch depth, prime count and ceil-log2.
// All functions are usable in constant expressions for parameter/port sizing.
package conv_il_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Deinterleave mirrors the depths so each symbol sees (BRANCHES-1)*UNIT_DEPTH shifts end to end.
  function automatic int branch_depth(input int b, input int branches, input int unit_depth,
                                      input int deint);
    return (deint != 0) ? (branches - 1 - b) * unit_depth : b * unit_depth;
  endfunction

  function automatic int prime_cnt(input int branches, input int unit_depth);
    return branches * (branches - 1) * unit_depth;
  endfunction

endpackage

// File: rtl/branch_delay_line.sv
// Enable-gated shift register forming one commutator branch; dout is the oldest cell.
// DEPTH=0 degenerates to a wire so the zero-delay branch passes the input straight through.
module branch_delay_line #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, reset, shift_en};
      assign dout      = din;
    end else begin : g_shift
      logic [DATA_W-1:0] cell_q [DEPTH];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < DEPTH; i++) cell_q[i] <= '0;
        end else if (shift_en) begin
          cell_q[0] <= din;
          for (int i = 1; i < DEPTH; i++) cell_q[i] <= cell_q[i-1];
        end
      end

      assign dout = cell_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/conv_interleaver.sv
// Forney convolutional (de)interleaver: a commutator steers accepted symbols over BRANCHES
// enable-gated delay lines; the selected branch's tail is registered to the output.
module conv_interleaver
  import conv_il_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BRANCHES   = 12,
  parameter int UNIT_DEPTH = 17,
  parameter int DEINT      = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       in_sync,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [clog2(BRANCHES)-1:0] out_branch,
  output logic                       out_primed
);

  localparam int BR_W  = clog2(BRANCHES);
  localparam int PRIME = prime_cnt(BRANCHES, UNIT_DEPTH);
  localparam int PC_W  = clog2(PRIME + 1);
  localparam logic [PC_W-1:0] PRIME_C = PC_W'(PRIME);
  localparam logic [BR_W-1:0] LAST_BR = BR_W'(BRANCHES - 1);

  logic [BR_W-1:0]   comm_q, comm_d;
  logic [PC_W-1:0]   prime_q, prime_d;
  logic              primed_q, primed_d;
  logic              valid_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic [BR_W-1:0]   branch_q, branch_d;

  logic [BR_W-1:0]     sel_w;
  logic [BRANCHES-1:0] shift_en_w;
  logic [DATA_W-1:0]   tail_w [BRANCHES];
  logic [DATA_W-1:0]   tail_sel_w;

  // Sync overrides the commutator without touching branch contents.
  assign sel_w = in_sync ? '0 : comm_q;

  generate
    for (genvar gi = 0; gi < BRANCHES; gi++) begin : g_branch
      assign shift_en_w[gi] = in_valid && (sel_w == BR_W'(gi));

      branch_delay_line #(
        .DATA_W (DATA_W),
        .DEPTH  (branch_depth(gi, BRANCHES, UNIT_DEPTH, DEINT))
      ) u_line (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en_w[gi]),
        .din      (in_data),
        .dout     (tail_w[gi])
      );
    end
  endgenerate

  always_comb begin
    tail_sel_w = '0;
    for (int b = 0; b < BRANCHES; b++) begin
      if (sel_w == BR_W'(b)) tail_sel_w = tail_w[b];
    end
  end

  always_comb begin
    comm_d   = comm_q;
    prime_d  = prime_q;
    data_d   = data_q;
    branch_d = branch_q;
    if (in_valid) begin
      comm_d   = (sel_w == LAST_BR) ? '0 : sel_w + 1'b1;
      data_d   = tail_sel_w;
      branch_d = sel_w;
      if (prime_q != PRIME_C) prime_d = prime_q + 1'b1;
    end
    primed_d = primed_q | (prime_d >= PRIME_C);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      comm_q   <= '0;
      prime_q  <= '0;
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      branch_q <= '0;
    end else begin
      comm_q   <= comm_d;
      prime_q  <= prime_d;
      primed_q <= primed_d;
      valid_q  <= in_valid;
      data_q   <= data_d;
      branch_q <= branch_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_branch = branch_q;
  assign out_primed = primed_q;

endmodule

// File: tb/tb_conv_interleaver.sv
// Bench for conv_interleaver: small 3-branch instances against a per-branch history model,
// plus a default-parameter interleave->deinterleave loopback checked against a pure delay.
module tb_conv_interleaver;

  localparam int LOOP_DELAY = 12 * 11 * 17;
  localparam int LOOP_CYC   = 10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  // index 0: B=3,U=1 interleave; index 1: B=3,U=1 deinterleave
  logic       s_valid   [2];
  logic       s_sync    [2];
  logic [7:0] s_data    [2];
  logic       s_ovalid  [2];
  logic [7:0] s_odata   [2];
  logic [1:0] s_obranch [2];
  logic       s_oprimed [2];

  logic       l_valid, l_sync;
  logic [7:0] l_data;
  logic       a_ovalid, a_oprimed, b_ovalid, b_oprimed;
  logic [7:0] a_odata, b_odata;
  logic [3:0] a_obranch, b_obranch;

  conv_interleaver #(.DATA_W(8), .BRANCHES(3), .UNIT_DEPTH(1), .DEINT(0)) u_il3 (
    .clk(clk), .reset(reset), .in_valid(s_valid[0]), .in_sync(s_sync[0]), .in_data(s_data[0]),
    .out_valid(s_ovalid[0]), .out_data(s_odata[0]), .out_branch(s_obranch[0]),
    .out_primed(s_oprimed[0]));

  conv_interleaver #(.DATA_W(8), .BRANCHES(3), .UNIT_DEPTH(1), .DEINT(1)) u_dl3 (
    .clk(clk), .reset(reset), .in_valid(s_valid[1]), .in_sync(s_sync[1]), .in_data(s_data[1]),
    .out_valid(s_ovalid[1]), .out_data(s_odata[1]), .out_branch(s_obranch[1]),
    .out_primed(s_oprimed[1]));

  conv_interleaver #(.DATA_W(8), .BRANCHES(12), .UNIT_DEPTH(17), .DEINT(0)) u_il (
    .clk(clk), .reset(reset), .in_valid(l_valid), .in_sync(l_sync), .in_data(l_data),
    .out_valid(a_ovalid), .out_data(a_odata), .out_branch(a_obranch), .out_primed(a_oprimed));

  conv_interleaver #(.DATA_W(8), .BRANCHES(12), .UNIT_DEPTH(17), .DEINT(1)) u_dl (
    .clk(clk), .reset(reset), .in_valid(a_ovalid), .in_sync(1'b0), .in_data(a_odata),
    .out_valid(b_ovalid), .out_data(b_odata), .out_branch(b_obranch), .out_primed(b_oprimed));

  // Reference model for the small instances: per-branch history of symbols written.
  logic [7:0] m_hist [2][3][256];
  int         m_n    [2][3];
  int         m_comm [2];
  int         m_cnt  [2];
  logic       m_primed [2];
  logic       m_valid  [2];
  logic [7:0] m_data   [2];
  logic [1:0] m_branch [2];

  function automatic int mdepth(input int i, input int b);
    return (i == 1) ? (2 - b) : b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_comm[i] = 0; m_cnt[i] = 0; m_primed[i] = 1'b0; m_valid[i] = 1'b0;
      m_data[i] = 8'h00; m_branch[i] = 2'd0;
      for (int b = 0; b < 3; b++) m_n[i][b] = 0;
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = 1'b0; s_sync[i] = 1'b0; s_data[i] = 8'h00;
    end
    l_valid = 1'b0; l_sync = 1'b0; l_data = 8'h00;
  endtask

  task automatic do_reset();
    idle_all();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // Drive one cycle on a small instance and advance the model; samples land 1 time unit after the edge.
  task automatic step3(input int i, input logic v, input logic s, input logic [7:0] d);
    int b, dep, n;
    s_valid[i] = v; s_sync[i] = s; s_data[i] = d;
    if (v) begin
      b   = s ? 0 : m_comm[i];
      dep = mdepth(i, b);
      n   = m_n[i][b];
      m_hist[i][b][n] = d;
      m_n[i][b]  = n + 1;
      m_data[i]  = (n >= dep) ? m_hist[i][b][n - dep] : 8'h00;
      m_branch[i] = 2'(b);
      m_comm[i]  = (b == 2) ? 0 : b + 1;
      if (m_cnt[i] < 6) m_cnt[i]++;
      m_primed[i] = (m_cnt[i] >= 6);
    end
    m_valid[i] = v;
    @(posedge clk);
    #1;
    $display("inst%0d v=%0b sync=%0b in=%02h -> valid=%0b out=%02h br=%0d primed=%0b",
             i, v, s, d, s_ovalid[i], s_odata[i], s_obranch[i], s_oprimed[i]);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_all();
    #2;
    for (int i = 0; i < 2; i++) begin
      checks++; if (s_ovalid[i] !== 1'b0) begin errors++; $display("FAIL reset_valid inst%0d got %0b want 0", i, s_ovalid[i]); end
      checks++; if (s_odata[i] !== 8'h00) begin errors++; $display("FAIL reset_data inst%0d got %02h want 00", i, s_odata[i]); end
      checks++; if (s_obranch[i] !== 2'd0) begin errors++; $display("FAIL reset_branch inst%0d got %0d want 0", i, s_obranch[i]); end
      checks++; if (s_oprimed[i] !== 1'b0) begin errors++; $display("FAIL reset_primed inst%0d got %0b want 0", i, s_oprimed[i]); end
    end
    checks++;
    if ({a_ovalid, a_odata, a_obranch, a_oprimed, b_ovalid, b_odata, b_obranch, b_oprimed} !== '0) begin
      errors++; $display("FAIL reset_default got nonzero outputs a=%02h b=%02h", a_odata, b_odata);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_interleave_vector();
    logic [7:0] exp_d [9];
    exp_d = '{8'd1, 8'd0, 8'd0, 8'd4, 8'd2, 8'd0, 8'd7, 8'd5, 8'd3};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step3(0, 1'b1, k == 0, 8'(k + 1));
      checks++; if (s_ovalid[0] !== 1'b1) begin errors++; $display("FAIL il_vec_valid k=%0d got %0b want 1", k, s_ovalid[0]); end
      checks++; if (s_odata[0] !== exp_d[k]) begin errors++; $display("FAIL il_vec_data k=%0d got %0d want %0d", k, s_odata[0], exp_d[k]); end
      checks++; if (s_obranch[0] !== 2'(k % 3)) begin errors++; $display("FAIL il_vec_branch k=%0d got %0d want %0d", k, s_obranch[0], k % 3); end
    end
    idle_all();
  endtask

  task automatic test_deinterleave_vector();
    logic [7:0] in_d  [9];
    logic [7:0] exp_d [9];
    in_d  = '{8'd1, 8'd0, 8'd0, 8'd4, 8'd2, 8'd0, 8'd7, 8'd5, 8'd3};
    exp_d = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step3(1, 1'b1, 1'b0, in_d[k]);
      checks++; if (s_odata[1] !== exp_d[k]) begin errors++; $display("FAIL dl_vec_data k=%0d got %0d want %0d", k, s_odata[1], exp_d[k]); end
      checks++; if (s_oprimed[1] !== (k >= 5)) begin errors++; $display("FAIL dl_vec_primed k=%0d got %0b want %0b", k, s_oprimed[1], k >= 5); end
    end
    idle_all();
  endtask

  task automatic test_sync_realign();
    logic v, s;
    do_reset();
    for (int k = 0; k < 4; k++) step3(0, 1'b1, 1'b0, 8'($urandom));
    step3(0, 1'b1, 1'b1, 8'($urandom));
    checks++; if (s_obranch[0] !== 2'd0) begin errors++; $display("FAIL sync_branch got %0d want 0", s_obranch[0]); end
    checks++; if (s_odata[0] !== m_data[0]) begin errors++; $display("FAIL sync_data got %02h want %02h", s_odata[0], m_data[0]); end
    step3(0, 1'b1, 1'b0, 8'($urandom));
    checks++; if (s_obranch[0] !== 2'd1) begin errors++; $display("FAIL sync_next_branch got %0d want 1", s_obranch[0]); end
    for (int k = 0; k < 60; k++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 7) == 0);
      step3(0, v, s, 8'($urandom));
      checks++; if (s_ovalid[0] !== m_valid[0]) begin errors++; $display("FAIL rand_valid k=%0d got %0b want %0b", k, s_ovalid[0], m_valid[0]); end
      checks++; if (s_odata[0] !== m_data[0]) begin errors++; $display("FAIL rand_data k=%0d got %02h want %02h", k, s_odata[0], m_data[0]); end
      checks++; if (s_obranch[0] !== m_branch[0]) begin errors++; $display("FAIL rand_branch k=%0d got %0d want %0d", k, s_obranch[0], m_branch[0]); end
      checks++; if (s_oprimed[0] !== m_primed[0]) begin errors++; $display("FAIL rand_primed k=%0d got %0b want %0b", k, s_oprimed[0], m_primed[0]); end
    end
    idle_all();
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      d = 8'($urandom);
      if (d == 8'hA5) d = 8'h5A;
      step3(1, 1'b1, 1'b0, d);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (s_ovalid[1] !== 1'b0) begin errors++; $display("FAIL async_valid got %0b want 0", s_ovalid[1]); end
    checks++; if (s_odata[1] !== 8'h00) begin errors++; $display("FAIL async_data got %02h want 00", s_odata[1]); end
    checks++; if (s_obranch[1] !== 2'd0) begin errors++; $display("FAIL async_branch got %0d want 0", s_obranch[1]); end
    checks++; if (s_oprimed[1] !== 1'b0) begin errors++; $display("FAIL async_primed got %0b want 0", s_oprimed[1]); end
    idle_all();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < 9; k++) begin
      if (k == 0) d = 8'hA5;
      else begin
        d = 8'($urandom);
        if (d == 8'hA5) d = 8'h5A;
      end
      step3(1, 1'b1, 1'b0, d);
      checks++; if ((s_odata[1] === 8'hA5) !== (k == 6)) begin errors++; $display("FAIL a5_timing k=%0d got %02h", k, s_odata[1]); end
      checks++; if (s_odata[1] !== m_data[1]) begin errors++; $display("FAIL post_reset_data k=%0d got %02h want %02h", k, s_odata[1], m_data[1]); end
      checks++; if (s_obranch[1] !== 2'(k % 3)) begin errors++; $display("FAIL post_reset_branch k=%0d got %0d want %0d", k, s_obranch[1], k % 3); end
    end
    idle_all();
  endtask

  task automatic test_idle_gap();
    do_reset();
    for (int k = 0; k < 20; k++) step3(0, 1'b1, 1'b0, 8'($urandom));
    for (int k = 0; k < 100; k++) begin
      step3(0, 1'b0, k[0], 8'($urandom));
      checks++; if (s_ovalid[0] !== 1'b0) begin errors++; $display("FAIL gap_valid k=%0d got %0b want 0", k, s_ovalid[0]); end
      checks++; if (s_odata[0] !== m_data[0]) begin errors++; $display("FAIL gap_data k=%0d got %02h want %02h", k, s_odata[0], m_data[0]); end
      checks++; if (s_obranch[0] !== m_branch[0]) begin errors++; $display("FAIL gap_branch k=%0d got %0d want %0d", k, s_obranch[0], m_branch[0]); end
      checks++; if (s_oprimed[0] !== m_primed[0]) begin errors++; $display("FAIL gap_primed k=%0d got %0b want %0b", k, s_oprimed[0], m_primed[0]); end
    end
    for (int k = 0; k < 20; k++) begin
      step3(0, 1'b1, 1'b0, 8'($urandom));
      checks++; if (s_odata[0] !== m_data[0]) begin errors++; $display("FAIL resume_data k=%0d got %02h want %02h", k, s_odata[0], m_data[0]); end
      checks++; if (s_obranch[0] !== m_branch[0]) begin errors++; $display("FAIL resume_branch k=%0d got %0d want %0d", k, s_obranch[0], m_branch[0]); end
    end
    idle_all();
  endtask

  task automatic test_loopback();
    logic [7:0] hist_in [16384];
    int n_in, n_out;
    logic v, v_d1, v_d2;
    logic [7:0] d, exp_d;
    n_in = 0; n_out = 0; v_d1 = 1'b0; v_d2 = 1'b0;
    do_reset();
    for (int c = 0; c < LOOP_CYC + 2; c++) begin
      v = (c < LOOP_CYC) ? ($urandom_range(0, 1) == 1) : 1'b0;
      d = 8'($urandom);
      l_valid = v; l_data = d;
      @(posedge clk);
      #1;
      if (v) begin
        hist_in[n_in] = d;
        n_in++;
      end
      v_d2 = v_d1;
      v_d1 = v;
      checks++; if (a_ovalid !== v_d1) begin errors++; $display("FAIL loop_il_valid c=%0d got %0b want %0b", c, a_ovalid, v_d1); end
      checks++; if (b_ovalid !== v_d2) begin errors++; $display("FAIL loop_dl_valid c=%0d got %0b want %0b", c, b_ovalid, v_d2); end
      if (b_ovalid === 1'b1) begin
        exp_d = (n_out >= LOOP_DELAY) ? hist_in[n_out - LOOP_DELAY] : 8'h00;
        checks++; if (b_odata !== exp_d) begin errors++; $display("FAIL loop_data n=%0d got %02h want %02h", n_out, b_odata, exp_d); end
        n_out++;
      end
    end
    $display("loopback: %0d symbols in, %0d symbols out", n_in, n_out);
    checks++; if (n_out !== n_in) begin errors++; $display("FAIL loop_count got %0d want %0d", n_out, n_in); end
    checks++; if (b_oprimed !== (n_in >= LOOP_DELAY)) begin errors++; $display("FAIL loop_primed got %0b want %0b", b_oprimed, n_in >= LOOP_DELAY); end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_interleave_vector();
    test_deinterleave_vector();
    test_sync_realign();
    test_async_reset();
    test_idle_gap();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
